// File: rtl/csr_access_unit_if.sv
// ============================================================================
// Module      : csr_access_unit_if
// Description : Core request/response and CSR responder bus for csr_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_access_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqOp;
  logic [11:0] reqAddress;
  logic [31:0] reqWriteData;
  logic        reqWriteSuppress;
  logic        respValid;
  logic [31:0] respData;
  logic        respIllegal;
  logic        csrReadEnable;
  logic [11:0] csrReadAddress;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;
  logic        csrWriteEnable;
  logic [11:0] csrWriteAddress;
  logic [31:0] csrWriteData;

  // Access unit side
  modport slave (
    input  reqValid, reqOp, reqAddress, reqWriteData, reqWriteSuppress,
    output reqReady, respValid, respData, respIllegal,
    output csrReadEnable, csrReadAddress, csrWriteEnable, csrWriteAddress, csrWriteData,
    input  csrReadData, csrRequestOutput
  );

  // Core and responder side
  modport master (
    output reqValid, reqOp, reqAddress, reqWriteData, reqWriteSuppress,
    input  reqReady, respValid, respData, respIllegal,
    input  csrReadEnable, csrReadAddress, csrWriteEnable, csrWriteAddress, csrWriteData,
    output csrReadData, csrRequestOutput
  );
endinterface

`default_nettype wire

// File: rtl/csr_access_unit.sv
// ============================================================================
// Module      : csr_access_unit
// Description : Sequences CSR RW/RS/RC accesses as read, optional write, response.
//               Define CSR_ACCESS_READONLY_CHECK_EN to reject writes to read-only CSRs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_access_unit (
  input  logic           clk,
  input  logic           rst,
  csr_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] c_op_none = 2'b00;
  localparam logic [1:0] c_op_rw   = 2'b01;
  localparam logic [1:0] c_op_rs   = 2'b10;

  state_t      r_state, w_state;
  logic [1:0]  r_op, w_op;
  logic [11:0] r_addr, w_addr;
  logic [31:0] r_operand, w_operand;
  logic        r_suppress, w_suppress;
  logic [31:0] r_old, w_old;
  logic        r_illegal, w_illegal;

  logic        r_ready;
  logic        r_rd_en, w_rd_en;
  logic [11:0] r_rd_addr, w_rd_addr;
  logic        r_wr_en, w_wr_en;
  logic [11:0] r_wr_addr, w_wr_addr;
  logic [31:0] r_wr_data, w_wr_data;
  logic        r_resp_valid, w_resp_valid;
  logic [31:0] r_resp_data, w_resp_data;
  logic        r_resp_illegal, w_resp_illegal;

  logic        w_accept;
  logic [31:0] w_read_value;
  logic [31:0] w_new_value;
  logic        w_write_required;
  logic        w_ro_violation;

  assign w_accept         = bus.reqValid && r_ready;
  assign w_read_value     = bus.csrRequestOutput ? bus.csrReadData : 32'd0;
  assign w_write_required = (r_op == c_op_rw) || !r_suppress;

`ifdef CSR_ACCESS_READONLY_CHECK_EN
  assign w_ro_violation   = (r_addr[11:10] == 2'b11);
`else
  assign w_ro_violation   = 1'b0;
`endif

  // Only consumed on the READ->WRITE edge, so it works from the live read data
  always_comb begin
    w_new_value = r_operand;
    case (r_op)
      c_op_rw: w_new_value = r_operand;
      c_op_rs: w_new_value = w_read_value | r_operand;
      default: w_new_value = w_read_value & ~r_operand;
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_op       = r_op;
    w_addr     = r_addr;
    w_operand  = r_operand;
    w_suppress = r_suppress;
    w_old      = r_old;
    w_illegal  = r_illegal;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_op       = bus.reqOp;
          w_addr     = bus.reqAddress;
          w_operand  = bus.reqWriteData;
          w_suppress = bus.reqWriteSuppress;
          w_old      = 32'd0;
          if (bus.reqOp == c_op_none) begin
            w_illegal = 1'b1;
            w_state   = DONE;
          end else begin
            w_illegal = 1'b0;
            w_state   = READ;
          end
        end
      end
      READ: begin
        if (!bus.csrRequestOutput || (w_write_required && w_ro_violation)) begin
          w_old     = 32'd0;
          w_illegal = 1'b1;
          w_state   = DONE;
        end else begin
          w_old   = w_read_value;
          w_state = w_write_required ? WRITE : DONE;
        end
      end
      WRITE:   w_state = DONE;
      default: w_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so every strobe comes straight off a flop
  always_comb begin
    w_rd_en        = (w_state == READ);
    w_rd_addr      = w_rd_en ? w_addr : 12'd0;
    w_wr_en        = (w_state == WRITE);
    w_wr_addr      = w_wr_en ? w_addr : 12'd0;
    w_wr_data      = w_wr_en ? w_new_value : 32'd0;
    w_resp_valid   = (w_state == DONE);
    w_resp_data    = w_resp_valid ? w_old : 32'd0;
    w_resp_illegal = w_resp_valid ? w_illegal : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_op           <= 2'd0;
      r_addr         <= 12'd0;
      r_operand      <= 32'd0;
      r_suppress     <= 1'b0;
      r_old          <= 32'd0;
      r_illegal      <= 1'b0;
      r_ready        <= 1'b1;
      r_rd_en        <= 1'b0;
      r_rd_addr      <= 12'd0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= 12'd0;
      r_wr_data      <= 32'd0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= 32'd0;
      r_resp_illegal <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_op           <= w_op;
      r_addr         <= w_addr;
      r_operand      <= w_operand;
      r_suppress     <= w_suppress;
      r_old          <= w_old;
      r_illegal      <= w_illegal;
      r_ready        <= (w_state == IDLE);
      r_rd_en        <= w_rd_en;
      r_rd_addr      <= w_rd_addr;
      r_wr_en        <= w_wr_en;
      r_wr_addr      <= w_wr_addr;
      r_wr_data      <= w_wr_data;
      r_resp_valid   <= w_resp_valid;
      r_resp_data    <= w_resp_data;
      r_resp_illegal <= w_resp_illegal;
    end
  end

  assign bus.reqReady        = r_ready;
  assign bus.csrReadEnable   = r_rd_en;
  assign bus.csrReadAddress  = r_rd_addr;
  assign bus.csrWriteEnable  = r_wr_en;
  assign bus.csrWriteAddress = r_wr_addr;
  assign bus.csrWriteData    = r_wr_data;
  assign bus.respValid       = r_resp_valid;
  assign bus.respData        = r_resp_data;
  assign bus.respIllegal     = r_resp_illegal;

endmodule

`default_nettype wire

// File: tb/tb_csr_access_unit.sv
// ============================================================================
// Module      : tb_csr_access_unit
// Description : Directed bench for csr_access_unit with a small CSR responder model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_access_unit;

  logic clk;
  logic rst;
  csr_access_unit_if bus();

  csr_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  logic [31:0] csr_b00, csr_300, csr_305, csr_c00;

  // Responders: 0xB00, 0x300, 0x305 writable; 0xC00 read-only
  always_comb begin
    bus.csrRequestOutput = 1'b0;
    bus.csrReadData      = 32'd0;
    if (bus.csrReadEnable) begin
      case (bus.csrReadAddress)
        12'hB00: begin bus.csrRequestOutput = 1'b1; bus.csrReadData = csr_b00; end
        12'h300: begin bus.csrRequestOutput = 1'b1; bus.csrReadData = csr_300; end
        12'h305: begin bus.csrRequestOutput = 1'b1; bus.csrReadData = csr_305; end
        12'hC00: begin bus.csrRequestOutput = 1'b1; bus.csrReadData = csr_c00; end
        default: ;
      endcase
    end
  end

  initial begin
    csr_b00 = 32'h0000_0123;
    csr_300 = 32'h0000_00F0;
    csr_305 = 32'h0000_1000;
    csr_c00 = 32'h0000_0077;
  end

  always @(posedge clk) begin
    if (bus.csrWriteEnable) begin
      case (bus.csrWriteAddress)
        12'hB00: csr_b00 <= bus.csrWriteData;
        12'h300: csr_300 <= bus.csrWriteData;
        12'h305: csr_305 <= bus.csrWriteData;
        default: ;
      endcase
    end
  end

  // Cycle-by-cycle exclusivity and zero-when-idle rules
  always @(negedge clk) begin
    if (bus.csrReadEnable && bus.csrWriteEnable) viol++;
    if (bus.csrReadEnable && bus.respValid) viol++;
    if (bus.csrWriteEnable && bus.respValid) viol++;
    if (!bus.respValid && (bus.respData != 32'd0 || bus.respIllegal)) viol++;
    if (!bus.csrReadEnable && bus.csrReadAddress != 12'd0) viol++;
    if (!bus.csrWriteEnable && (bus.csrWriteAddress != 12'd0 || bus.csrWriteData != 32'd0)) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          lat, n_rd, n_wr, wr_cycle;
  logic [11:0] rd_addr, wr_addr;
  logic [31:0] wr_data, rsp_data;
  logic        rsp_ill;

  task automatic run_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                         input logic s);
    lat = 0; n_rd = 0; n_wr = 0; wr_cycle = 0;
    rd_addr = 12'd0; wr_addr = 12'd0; wr_data = 32'd0; rsp_data = 32'hFFFF_FFFF; rsp_ill = 1'bx;
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqOp = op; bus.reqAddress = a;
    bus.reqWriteData = d; bus.reqWriteSuppress = s;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0; bus.reqOp = 2'd0; bus.reqAddress = 12'd0;
    bus.reqWriteData = 32'd0; bus.reqWriteSuppress = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.csrReadEnable) begin n_rd++; rd_addr = bus.csrReadAddress; end
      if (bus.csrWriteEnable) begin
        n_wr++; wr_cycle = c; wr_addr = bus.csrWriteAddress; wr_data = bus.csrWriteData;
      end
      if (bus.respValid) begin
        lat = c; rsp_data = bus.respData; rsp_ill = bus.respIllegal;
        break;
      end
    end
  endtask

  task automatic verify(input string tag, input int e_lat, input int e_rd, input int e_wr,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata, input logic e_ill);
    check({tag, ".latency"}, lat, e_lat);
    check({tag, ".reads"}, n_rd, e_rd);
    check({tag, ".writes"}, n_wr, e_wr);
    if (e_wr != 0) check({tag, ".wdata"}, wr_data, e_wdata);
    check({tag, ".rdata"}, rsp_data, e_rdata);
    check({tag, ".illegal"}, {31'd0, rsp_ill}, {31'd0, e_ill});
  endtask

  int pulses;

  initial begin
    rst = 1'b1;
    bus.reqValid = 1'b0; bus.reqOp = 2'd0; bus.reqAddress = 12'd0;
    bus.reqWriteData = 32'd0; bus.reqWriteSuppress = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.ready", {31'd0, bus.reqReady}, 32'd1);
    check("reset.resp_valid", {31'd0, bus.respValid}, 32'd0);
    check("reset.rd_en", {31'd0, bus.csrReadEnable}, 32'd0);
    check("reset.wr_en", {31'd0, bus.csrWriteEnable}, 32'd0);

    // RS with suppressed operand: read only
    run_req(2'b10, 12'hB00, 32'd0, 1'b1);
    verify("rs_b00", 2, 1, 0, 32'd0, 32'h123, 1'b0);
    check("rs_b00.raddr", {20'd0, rd_addr}, 32'hB00);

    // RC 0x30 from 0xF0 -> 0xC0 written in cycle 2
    run_req(2'b11, 12'h300, 32'h30, 1'b0);
    verify("rc_300", 3, 1, 1, 32'hC0, 32'hF0, 1'b0);
    check("rc_300.waddr", {20'd0, wr_addr}, 32'h300);
    check("rc_300.wcycle", wr_cycle, 2);

    // Unclaimed address
    run_req(2'b01, 12'h7C0, 32'hDEAD, 1'b0);
    verify("rw_7c0", 2, 1, 0, 32'd0, 32'd0, 1'b1);

    // Write to read-only space
`ifdef CSR_ACCESS_READONLY_CHECK_EN
    run_req(2'b01, 12'hC00, 32'h5, 1'b0);
    verify("rw_c00", 2, 1, 0, 32'd0, 32'd0, 1'b1);
`else
    run_req(2'b01, 12'hC00, 32'h5, 1'b0);
    verify("rw_c00", 3, 1, 1, 32'h5, 32'h77, 1'b0);
    check("rw_c00.waddr", {20'd0, wr_addr}, 32'hC00);
`endif

    // Reserved op
    run_req(2'b00, 12'h300, 32'h1, 1'b0);
    verify("op00", 1, 0, 0, 32'd0, 32'd0, 1'b1);

    // RS 0x0F on 0x1000 -> 0x100F
    run_req(2'b10, 12'h305, 32'h0F, 1'b0);
    verify("rs_305", 3, 1, 1, 32'h100F, 32'h1000, 1'b0);

    // RW 0x55 over 0xC0
    run_req(2'b01, 12'h300, 32'h55, 1'b0);
    verify("rw_300", 3, 1, 1, 32'h55, 32'hC0, 1'b0);

    // RC with suppress: no write
    run_req(2'b11, 12'h305, 32'hFF, 1'b1);
    verify("rc_305_sup", 2, 1, 0, 32'd0, 32'h100F, 1'b0);

    // RW always writes, even with suppress set
    run_req(2'b01, 12'h300, 32'd0, 1'b1);
    verify("rw_300_sup", 3, 1, 1, 32'd0, 32'h55, 1'b0);

    // Reset during WRITE
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqOp = 2'b01; bus.reqAddress = 12'h300;
    bus.reqWriteData = 32'hAAAA; bus.reqWriteSuppress = 1'b0;
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw.wr_before", {31'd0, bus.csrWriteEnable}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstw.wr_en", {31'd0, bus.csrWriteEnable}, 32'd0);
    check("rstw.wdata", bus.csrWriteData, 32'd0);
    check("rstw.ready", {31'd0, bus.reqReady}, 32'd1);
    check("rstw.resp_valid", {31'd0, bus.respValid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.respValid || bus.csrWriteEnable) pulses++;
    end
    check("rstw.no_activity", pulses, 0);
    run_req(2'b10, 12'h300, 32'd0, 1'b1);
    verify("post_rst", 2, 1, 0, 32'd0, 32'd0, 1'b0);

    // Back-to-back reserved ops: accept every IDLE cycle
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqOp = 2'b00; bus.reqAddress = 12'h123;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.respValid) pulses++;
    end
    bus.reqValid = 1'b0; bus.reqAddress = 12'd0;
    check("b2b.responses", pulses, 3);

    repeat (2) @(negedge clk);
    check("invariants", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 Parameters: none; the module SHALL be fully defined by its ports and one macro.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 reqValid  input  1  core presents a CSR instruction.
REQ-005 reqReady  output  1  high only in IDLE; a request is accepted on a clock edge where reqValid && reqReady.
REQ-006 reqOp  input  2  01 RW (write), 10 RS (set bits), 11 RC (clear bits), 00 reserved.
REQ-007 reqAddress  input  12  CSR address.
REQ-008 reqWriteData  input  32  rs1/uimm operand.
REQ-009 reqWriteSuppress  input  1  operand source is x0/uimm=0; set or clear performs no write.
REQ-010 respValid  output  1  one-cycle completion pulse.
REQ-011 respData  output  32  CSR value before modification; valid while respValid.
REQ-012 respIllegal  output  1  access illegal; valid while respValid.
REQ-013 csrReadEnable  output  1  read strobe to all CSR responders.
REQ-014 csrReadAddress  output  12  read address.
REQ-015 csrReadData  input  32  OR of all responder read data; 0 from non-selected responders.
REQ-016 csrRequestOutput  input  1  OR of responder claim flags; same cycle as csrReadEnable.
REQ-017 csrWriteEnable  output  1  write strobe.
REQ-018 csrWriteAddress  output  12  write address.
REQ-019 csrWriteData  output  32  write data.

Function
REQ-020 The module SHALL implement states IDLE, READ, WRITE, DONE.
REQ-021 On acceptance the module SHALL latch op, address, operand and suppress, and go IDLE->READ.
REQ-022 In READ it SHALL drive csrReadEnable=1 and csrReadAddress=latched address for exactly one cycle, and capture csrReadData into an internal oldValue register at the end of that cycle.
REQ-023 If csrRequestOutput=0 in READ, the access SHALL be illegal: oldValue captured as 0, WRITE skipped, READ->DONE.
REQ-024 An access with op=00 SHALL be illegal: no read or write strobe, IDLE->DONE directly after acceptance.
REQ-025 newValue: RW = operand; RS = oldValue | operand; RC = oldValue & ~operand.
REQ-026 READ->WRITE when legal and write required; write is required for RW always, and for RS/RC only when reqWriteSuppress=0.
REQ-027 A legal access not requiring a write SHALL go READ->DONE.
REQ-028 In WRITE the module SHALL drive csrWriteEnable=1, csrWriteAddress=latched address and csrWriteData=newValue for exactly one cycle, then go to DONE.
REQ-029 In DONE the module SHALL assert respValid for one cycle with respData=oldValue and respIllegal set per REQ-023/024/036, then return to IDLE.
REQ-030 Latency from the acceptance edge to respValid high: 3 cycles with a write, 2 without, 1 for op=00.
REQ-031 csrReadEnable, csrWriteEnable and respValid SHALL never be high in the same cycle; respData and respIllegal SHALL be 0 whenever respValid=0.
REQ-032 Strobe outputs SHALL be registered state decodes, glitch-free; address and data buses SHALL be 0 when their strobe is low.
REQ-033 reqValid and request inputs are ignored outside IDLE; a back-to-back request SHALL be accepted on the edge after DONE.

Reset
REQ-034 Asserting rst at any time, including mid-access, SHALL immediately force state IDLE, clear all latched registers, and drive every output to 0 except reqReady, which SHALL be 1.
REQ-035 A write interrupted by reset SHALL not be reissued; the core re-presents the request.

Configuration
REQ-036 With CSR_ACCESS_READONLY_CHECK_EN defined, a required write to an address with bits [11:10]=11 SHALL be illegal: read still performed, WRITE skipped, respIllegal=1, respData=0. Without it, the write SHALL be issued normally and responders ignore it.

Verification
REQ-037 Responder with timer lower at 0xB00 = 0x0000_0123: RS, operand 0, suppress=1 -> one read strobe, no write, respValid 2 cycles after accept, respData=0x123, respIllegal=0.
REQ-038 Responder at 0x300 value 0x0000_00F0: RC, operand 0x30 -> csrWriteData=0x0000_00C0 on 0x300 in cycle 2, respData=0xF0 in cycle 3.
REQ-039 No responder claims 0x7C0 (csrRequestOutput=0): RW operand 0xDEAD -> no write strobe, respIllegal=1, respData=0.
REQ-040 With macro defined, RW 0x5 to 0xC00 -> respIllegal=1, no write; without macro -> write of 0x5 to 0xC00, respIllegal=0.
REQ-041 rst pulsed during WRITE -> csrWriteEnable drops asynchronously, no respValid, reqReady=1; next request completes normally.
REQ-042 op=00 -> no strobes, respValid 1 cycle after accept with respIllegal=1; back-to-back requests accepted on consecutive IDLE cycles.
